aes_shift_mix_seq: RTL and testbench

AES_SHIFT_MIX_SEQ -- requirements
Module: aes_shift_mix_seq

---
 rtl/aes_shift_mix_seq.sv | 125 ++++++++++++
 tb/tb_aes_shift_mix_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shift_mix_seq.sv
// AES ShiftRows + MixColumns round stage: one state at a time, MixColumns spread over
// 4/COLS_PER_CYCLE cycles, result held in DONE until the consumer takes it.
module aes_shift_mix_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("aes_shift_mix_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MIX  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Step of 4 truncates to 0, so a single MIX cycle wraps the counter immediately.
  localparam logic [1:0] ColStep = COLS_PER_CYCLE[1:0];

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0,
            xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1,
            xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  logic [1:0]   r_state;
  logic [127:0] r_work;
  logic [1:0]   r_col;
  logic         r_last;

  logic [1:0]   w_state_nxt;
  logic [127:0] w_work_nxt;
  logic [1:0]   w_col_nxt;
  logic         w_last_nxt;
  logic [1:0]   w_col_inc;
  logic [127:0] w_mixed;

  assign w_col_inc = r_col + ColStep;

  // Column g is in this cycle's window when (g - col) mod 4 < COLS_PER_CYCLE.
  for (genvar g = 0; g < 4; g++) begin : g_col
    logic [1:0] w_rel;
    logic       w_sel;
    assign w_rel = 2'(g) - r_col;
    assign w_sel = {30'd0, w_rel} < COLS_PER_CYCLE;
    assign w_mixed[127-32*g -: 32] = w_sel ? mix_col(r_work[127-32*g -: 32])
                                           : r_work[127-32*g -: 32];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_col_nxt   = r_col;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_work_nxt  = shift_rows(in_state);
          w_last_nxt  = in_last;
          w_col_nxt   = 2'd0;
          w_state_nxt = in_last ? S_DONE : S_MIX;
        end
      end
      S_MIX: begin
        if (!r_last) w_work_nxt = w_mixed;
        w_col_nxt = w_col_inc;
        if (w_col_inc == 2'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_col   <= 2'd0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_col   <= w_col_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_state = r_work;

endmodule

// File: tb/tb_aes_shift_mix_seq.sv
// Bench for aes_shift_mix_seq: three instances (1, 2, 4 columns per cycle) checked against a
// matrix-level ShiftRows/MixColumns model with FIPS-197 vectors and random states.
module tb_aes_shift_mix_seq;

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid_v;
  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [127:0] out_state_v [3];
  logic [127:0] in_state;
  logic         in_last;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  aes_shift_mix_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_state(in_state), .in_last(in_last), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_state(out_state_v[0]));
  aes_shift_mix_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_state(in_state), .in_last(in_last), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_state(out_state_v[1]));
  aes_shift_mix_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_state(in_state), .in_last(in_last), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_state(out_state_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Generic GF(2^8) multiply, shift-and-add with reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    int p, x, m;
    p = 0; x = a; m = b;
    while (m != 0) begin
      if (m % 2 == 1) p = p ^ x;
      x = x * 2;
      if (x >= 256) x = x ^ 'h11b;
      m = m / 2;
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s, input logic lst);
    logic [7:0] m [4][4];
    logic [7:0] t [4][4];
    logic [7:0] u [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = s[127-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = m[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        u[r][c] = lst ? t[r][c] : gmul(t[r][c], 2) ^ gmul(t[(r+1)%4][c], 3) ^
                                  t[(r+2)%4][c] ^ t[(r+3)%4][c];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = u[r][c];
    return o;
  endfunction

  // Called just after a rising edge with instance k idle and out_ready = 1.
  task automatic run_txn(input int k, input logic [127:0] st, input logic lst,
                         input string tag, output logic [127:0] got);
    int n;
    int lat;
    lat = lst ? 0 : (4 >> k);
    chk({tag, "_in_ready"}, 128'(in_ready_v[k]), 128'(1));
    in_state = st;
    in_last  = lst;
    in_valid_v[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    n = 0;
    while (!out_valid_v[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(lat));
    got = out_state_v[k];
    chk({tag, "_state"}, got, ref_model(st, lst));
    @(posedge clk); #1;
    chk({tag, "_out_valid_drop"}, 128'(out_valid_v[k]), 128'(0));
  endtask

  localparam logic [127:0] Fips = 128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin
    logic [127:0] got;
    logic [127:0] st;
    logic [127:0] held;
    logic [127:0] b2b_st [4];
    logic         b2b_last [4];
    int n;

    rst_n = 1'b0;
    in_valid_v = 3'b000;
    out_ready = 1'b1;
    in_state = '0;
    in_last = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", 128'(in_ready_v[k]), 128'(1));
      chk("reset_out_valid", 128'(out_valid_v[k]), 128'(0));
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_txn(0, Fips, 1'b0, "fips_mix", got);
    chk("fips_mix_vector", got, 128'h046681e5e0cb199a48f8d37a2806264c);
    run_txn(0, Fips, 1'b1, "fips_last", got);
    chk("fips_last_vector", got, 128'hd4bf5d30e0b452aeb84111f11e2798e5);

    for (int k = 0; k < 3; k++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      st[127:120] = 8'hdb;
      st[87:80]   = 8'h13;
      st[47:40]   = 8'h53;
      st[7:0]     = 8'h45;
      run_txn(k, st, 1'b0, "column", got);
      chk("column_value", 128'(got[127:96]), 128'(32'h8e4da1bc));
    end

    for (int i = 0; i < 9; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      run_txn(i % 3, st, 1'($urandom_range(0, 1)), "random", got);
    end

    // Backpressure with an ignored input pulse while DONE is held.
    out_ready = 1'b0;
    in_state = Fips;
    in_last = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    n = 0;
    while (!out_valid_v[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", 128'(n), 128'(4));
    held = ref_model(Fips, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 128'(out_valid_v[0]), 128'(1));
      chk("bp_out_state", out_state_v[0], held);
      chk("bp_in_ready", 128'(in_ready_v[0]), 128'(0));
      if (i == 3) begin
        in_state = ~Fips;
        in_last = 1'b1;
        in_valid_v[0] = 1'b1;
      end else begin
        in_valid_v[0] = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid_v[0] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid_v[0]), 128'(0));
    chk("bp_release_ready", 128'(in_ready_v[0]), 128'(1));

    // Reset in the middle of MIX, after two columns.
    in_state = Fips;
    in_last = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", 128'(out_valid_v[0]), 128'(0));
    chk("mid_reset_in_ready", 128'(in_ready_v[0]), 128'(1));
    #2;
    rst_n = 1'b1;
    run_txn(0, Fips, 1'b0, "post_reset", got);
    chk("post_reset_vector", got, 128'h046681e5e0cb199a48f8d37a2806264c);

    // Back-to-back with in_valid held high.
    for (int i = 0; i < 4; i++) begin
      b2b_st[i] = {$urandom, $urandom, $urandom, $urandom};
      b2b_last[i] = (i == 1);
    end
    in_valid_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_state = b2b_st[i];
      in_last = b2b_last[i];
      chk("b2b_accept_ready", 128'(in_ready_v[0]), 128'(1));
      @(posedge clk); #1;
      chk("b2b_busy", 128'(in_ready_v[0]), 128'(0));
      n = 0;
      while (!out_valid_v[0] && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_latency", 128'(n), 128'(b2b_last[i] ? 0 : 4));
      chk("b2b_state", out_state_v[0], ref_model(b2b_st[i], b2b_last[i]));
      @(posedge clk); #1;
      chk("b2b_out_valid_drop", 128'(out_valid_v[0]), 128'(0));
    end
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_final_idle", 128'(in_ready_v[0]), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
